// File: rtl/packet_injector.sv
// packet_injector: local-port packet source for a mesh router node.
// Turns a (dest_x, dest_y, len) request plus a stream of payload words into
// head / body / tail flits, throttled by a credit counter that mirrors the
// free space in the router's local input buffer.
module packet_injector #(
  parameter int MSB_SLOT = 5,
  parameter int DSIZE    = 1 << MSB_SLOT,
  parameter int RRSIZE   = 1 << (MSB_SLOT - 2),
  parameter int ROUTER_X = 0,
  parameter int ROUTER_Y = 0,
  parameter int CREDITS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [RRSIZE-1:0] req_dest_x,
  input  logic [RRSIZE-1:0] req_dest_y,
  input  logic [5:0]        req_len,
  input  logic              wr_valid,
  input  logic [29:0]       wr_data,
  output logic              wr_ready,
  output logic [DSIZE-1:0]  flit_out,
  output logic              flit_valid,
  input  logic              credit_in,
  output logic              pkt_done,
  output logic              credit_err
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEND_HEAD  = 2'd1,
    SEND_DATA  = 2'd2,
    SEND_ZTAIL = 2'd3
  } state_t;

  localparam logic [1:0] TYPE_HEAD = 2'b11;
  localparam logic [1:0] TYPE_BODY = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b10;

  localparam logic [3:0] SRC_X    = ROUTER_X[3:0];
  localparam logic [3:0] SRC_Y    = ROUTER_Y[3:0];
  localparam logic [3:0] CRED_MAX = CREDITS[3:0];

  state_t state, state_next;

  logic [RRSIZE-1:0] dest_x, dest_y;
  logic [5:0]        len;
  logic [5:0]        remaining;
  logic [3:0]        credit_cnt;

  // Per-cycle decisions made by the FSM
  logic              accept;
  logic              take;
  logic              emit;
  logic              last;
  logic [DSIZE-1:0]  emit_flit;

  logic              has_credit;

  assign has_credit = (credit_cnt != 4'd0);
  assign req_ready  = (state == IDLE);
  assign wr_ready   = (state == SEND_DATA) && has_credit;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the flit to emit this edge (if any)
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    take       = 1'b0;
    emit       = 1'b0;
    last       = 1'b0;
    emit_flit  = '0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = SEND_HEAD;
        end
      end
      SEND_HEAD: begin
        if (has_credit) begin
          emit       = 1'b1;
          emit_flit  = {dest_x, dest_y, SRC_X, SRC_Y, len, TYPE_HEAD};
          state_next = (len != 6'd0) ? SEND_DATA : SEND_ZTAIL;
        end
      end
      SEND_DATA: begin
        if (wr_valid && has_credit) begin
          emit = 1'b1;
          take = 1'b1;
          if (remaining > 6'd1) begin
            emit_flit = {wr_data, TYPE_BODY};
          end else begin
            emit_flit  = {wr_data, TYPE_TAIL};
            last       = 1'b1;
            state_next = IDLE;
          end
        end
      end
      SEND_ZTAIL: begin
        // Zero-length packets still need a tail to close the wormhole
        if (has_credit) begin
          emit       = 1'b1;
          last       = 1'b1;
          emit_flit  = {30'd0, TYPE_TAIL};
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, payload countdown and registered flit outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      dest_x     <= '0;
      dest_y     <= '0;
      len        <= '0;
      remaining  <= '0;
      flit_out   <= '0;
      flit_valid <= 1'b0;
      pkt_done   <= 1'b0;
    end else begin
      if (accept) begin
        dest_x    <= req_dest_x;
        dest_y    <= req_dest_y;
        len       <= req_len;
        remaining <= req_len;
      end else if (take) begin
        remaining <= remaining - 6'd1;
      end
      if (emit) begin
        flit_out <= emit_flit;
      end
      flit_valid <= emit;
      pkt_done   <= emit && last;
    end
  end

  // Credit accounting; an extra credit with a full counter is a protocol error
  always_ff @(posedge clk) begin
    if (!reset) begin
      credit_cnt <= CRED_MAX;
      credit_err <= 1'b0;
    end else begin
      case ({emit, credit_in})
        2'b10: credit_cnt <= credit_cnt - 4'd1;
        2'b01: begin
          if (credit_cnt == CRED_MAX) begin
            credit_err <= 1'b1;
          end else begin
            credit_cnt <= credit_cnt + 4'd1;
          end
        end
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_injector.sv
// tb_packet_injector: scoreboard bench for packet_injector. Expected flits
// are queued when a request is issued and checked as the DUT emits them.
module tb_packet_injector;

  localparam int CRED = 4;
  localparam int RX   = 3;
  localparam int RY   = 6;
  localparam logic [3:0] RX4 = 4'd3;
  localparam logic [3:0] RY4 = 4'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_dest_x = '0;
  logic [7:0]  req_dest_y = '0;
  logic [5:0]  req_len = '0;
  logic        wr_valid = 1'b0;
  logic [29:0] wr_data = '0;
  logic        wr_ready;
  logic [31:0] flit_out;
  logic        flit_valid;
  logic        credit_in = 1'b0;
  logic        pkt_done;
  logic        credit_err;

  packet_injector #(
    .MSB_SLOT(5), .ROUTER_X(RX), .ROUTER_Y(RY), .CREDITS(CRED)
  ) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dest_x(req_dest_x), .req_dest_y(req_dest_y), .req_len(req_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .flit_out(flit_out), .flit_valid(flit_valid),
    .credit_in(credit_in), .pkt_done(pkt_done), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          flits_seen = 0;
  logic [32:0] exp_q[$];     // {pkt_done, flit}
  logic [29:0] pay_q[$];
  int          fcyc_q[$];    // edge number of every valid flit
  logic [29:0] pdata[64];
  bit          feed_en = 1'b0;
  bit          auto_credit = 1'b0;
  bit          man_credit = 1'b0;
  bit          wr_ready_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor / scoreboard pop
  always @(negedge clk) begin : mon
    logic [32:0] e;
    if (flit_valid === 1'b1) begin
      flits_seen++;
      fcyc_q.push_back(cyc);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_flit got=%h pkt_done=%0b required=no flit", flit_out, pkt_done);
      end else begin
        e = exp_q.pop_front();
        if ({pkt_done, flit_out} !== e) begin
          miscompares++;
          $display("FAIL flit got=%h pkt_done=%0b required=%h pkt_done=%0b",
                   flit_out, pkt_done, e[31:0], e[32]);
        end
      end
    end else if (pkt_done !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("FAIL pkt_done_without_flit got=%0b required=0", pkt_done);
    end
  end

  // Payload source: presents the head of pay_q, pops it when consumed
  always @(posedge clk) begin : feeder
    bit take;
    take = wr_valid && wr_ready;
    if (wr_ready === 1'b1) wr_ready_seen = 1'b1;
    #2;
    if (take && pay_q.size() > 0) void'(pay_q.pop_front());
    wr_valid = feed_en && (pay_q.size() > 0);
    wr_data  = (pay_q.size() > 0) ? pay_q[0] : '0;
  end

  // Credit return: optional automatic return plus manual pulses
  always @(posedge clk) begin
    #1;
    credit_in = (auto_credit && flit_valid) || man_credit;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    man_credit = 1'b0;
    feed_en = 1'b0;
    exp_q.delete();
    pay_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Queue expectations and payload from pdata[], then hold req_valid until accepted.
  task automatic send_packet(input logic [7:0] dx, input logic [7:0] dy,
                             input logic [5:0] len, output int acc);
    exp_q.push_back({1'b0, dx, dy, RX4, RY4, len, 2'b11});
    if (len == 6'd0) begin
      exp_q.push_back({1'b1, 30'd0, 2'b10});
    end else begin
      for (int i = 0; i < int'(len); i++) begin
        pay_q.push_back(pdata[i]);
        if (i == int'(len) - 1) exp_q.push_back({1'b1, pdata[i], 2'b10});
        else                    exp_q.push_back({1'b0, pdata[i], 2'b01});
      end
    end
    feed_en = 1'b1;
    req_dest_x = dx;
    req_dest_y = dy;
    req_len = len;
    req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (req_ready === 1'b1) begin
        acc = cyc + 1;
        break;
      end
    end
    #1;
    req_valid = 1'b0;
    vectors++;
    if (acc < 0) begin
      miscompares++;
      $display("FAIL req_accept got=never required=accepted within 200 cycles");
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL drain got=%0d flits outstanding required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) pdata[i] = 30'($urandom);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors += 5;
    if (flit_valid !== 1'b0) begin miscompares++; $display("FAIL rst_flit_valid got=%b required=0", flit_valid); end
    if (req_ready !== 1'b1)  begin miscompares++; $display("FAIL rst_req_ready got=%b required=1", req_ready); end
    if (credit_err !== 1'b0) begin miscompares++; $display("FAIL rst_credit_err got=%b required=0", credit_err); end
    if (wr_ready !== 1'b0)   begin miscompares++; $display("FAIL rst_wr_ready got=%b required=0", wr_ready); end
    if (flit_out !== 32'd0)  begin miscompares++; $display("FAIL rst_flit_out got=%h required=0", flit_out); end
  endtask

  task automatic test_credit_overflow();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); man_credit = 1'b1;
      @(negedge clk); man_credit = 1'b0;
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (credit_err !== 1'b1) begin miscompares++; $display("FAIL credit_err_set got=%b required=1", credit_err); end
  endtask

  // Counter must still be 4: exactly 4 flits leave without credits, then
  // one credit releases one flit, then continuous credits stream at cnt==1.
  task automatic test_stall_and_simul();
    int acc, base, n;
    fill_random(8);
    base = flits_seen;
    @(negedge clk);
    send_packet(8'd5, 8'd1, 6'd8, acc);
    repeat (12) @(negedge clk);
    vectors += 3;
    if (flits_seen - base !== 4) begin miscompares++; $display("FAIL stall_count got=%0d required=4", flits_seen - base); end
    if (wr_ready !== 1'b0)       begin miscompares++; $display("FAIL stall_wr_ready got=%b required=0", wr_ready); end
    if (flit_valid !== 1'b0)     begin miscompares++; $display("FAIL stall_flit_valid got=%b required=0", flit_valid); end
    man_credit = 1'b1;
    @(negedge clk); man_credit = 1'b0;
    repeat (8) @(negedge clk);
    vectors += 2;
    if (flits_seen - base !== 5) begin miscompares++; $display("FAIL one_credit_count got=%0d required=5", flits_seen - base); end
    if (credit_err !== 1'b1)     begin miscompares++; $display("FAIL credit_err_sticky got=%b required=1", credit_err); end
    man_credit = 1'b1;
    wait_drain(40);
    man_credit = 1'b0;
    n = fcyc_q.size();
    vectors++;
    if (n >= 4 && (fcyc_q[n-1] - fcyc_q[n-4]) !== 3) begin
      miscompares++;
      $display("FAIL simul_credit_stream got=%0d cycles for 4 flits required=3", fcyc_q[n-1] - fcyc_q[n-4]);
    end
    do_reset();
  endtask

  task automatic test_basic();
    int acc, b;
    auto_credit = 1'b1;
    pdata[0] = 30'h1234567;
    pdata[1] = 30'h0ABCDEF;
    b = fcyc_q.size();
    @(negedge clk);
    send_packet(8'd2, 8'd3, 6'd2, acc);
    vectors++;
    if (req_ready !== 1'b0) begin miscompares++; $display("FAIL busy_req_ready got=%b required=0", req_ready); end
    wait_drain(20);
    vectors += 3;
    if (fcyc_q.size() < b + 3) begin
      miscompares++;
      $display("FAIL basic_timing got=%0d flits required=3", fcyc_q.size() - b);
    end else begin
      if (fcyc_q[b] !== acc + 1)   begin miscompares++; $display("FAIL head_latency got=%0d required=%0d", fcyc_q[b], acc + 1); end
      if (fcyc_q[b+1] !== acc + 2) begin miscompares++; $display("FAIL body_cycle got=%0d required=%0d", fcyc_q[b+1], acc + 2); end
      if (fcyc_q[b+2] !== acc + 3) begin miscompares++; $display("FAIL tail_cycle got=%0d required=%0d", fcyc_q[b+2], acc + 3); end
    end
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL idle_req_ready got=%b required=1", req_ready); end
  endtask

  task automatic test_len0();
    int acc, b;
    wr_ready_seen = 1'b0;
    b = fcyc_q.size();
    @(negedge clk);
    send_packet(8'd7, 8'd9, 6'd0, acc);
    wait_drain(20);
    vectors += 2;
    if (wr_ready_seen !== 1'b0) begin miscompares++; $display("FAIL len0_wr_ready got=1 required=0"); end
    if (fcyc_q.size() >= b + 2 && fcyc_q[b+1] !== fcyc_q[b] + 1) begin
      miscompares++;
      $display("FAIL len0_tail_cycle got=%0d required=%0d", fcyc_q[b+1], fcyc_q[b] + 1);
    end
  endtask

  task automatic test_back_to_back();
    int acc, acc2, b;
    fill_random(3);
    b = fcyc_q.size();
    @(negedge clk);
    send_packet(8'd1, 8'd4, 6'd3, acc);
    fill_random(1);
    send_packet(8'd6, 8'd2, 6'd1, acc2);
    wait_drain(60);
    vectors += 2;
    if (fcyc_q.size() < b + 6) begin
      miscompares++;
      $display("FAIL b2b_count got=%0d required=6", fcyc_q.size() - b);
    end else begin
      if (fcyc_q[b+4] - fcyc_q[b+3] !== 2) begin miscompares++; $display("FAIL b2b_gap got=%0d required=2", fcyc_q[b+4] - fcyc_q[b+3]); end
      if (acc2 !== fcyc_q[b+3] + 1)       begin miscompares++; $display("FAIL b2b_accept got=%0d required=%0d", acc2, fcyc_q[b+3] + 1); end
    end
  endtask

  task automatic test_reset_mid();
    int acc, base;
    fill_random(5);
    base = flits_seen;
    @(negedge clk);
    send_packet(8'd4, 8'd4, 6'd5, acc);
    for (int i = 0; i < 30; i++) begin
      if (flits_seen - base >= 2) break;
      @(negedge clk);
      #1;
    end
    reset = 1'b0;
    auto_credit = 1'b0;
    feed_en = 1'b0;
    exp_q.delete();
    pay_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    vectors += 4;
    if (flit_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_flit_valid got=%b required=0", flit_valid); end
    if (req_ready !== 1'b1)  begin miscompares++; $display("FAIL mid_rst_req_ready got=%b required=1", req_ready); end
    if (pkt_done !== 1'b0)   begin miscompares++; $display("FAIL mid_rst_pkt_done got=%b required=0", pkt_done); end
    if (flit_out !== 32'd0)  begin miscompares++; $display("FAIL mid_rst_flit_out got=%h required=0", flit_out); end
    // Four flits with no returned credits proves the counter is back at CREDITS
    fill_random(3);
    send_packet(8'd9, 8'd8, 6'd3, acc);
    wait_drain(30);
  endtask

  task automatic test_self_dest();
    int acc;
    do_reset();
    auto_credit = 1'b1;
    fill_random(1);
    @(negedge clk);
    send_packet(8'(RX), 8'(RY), 6'd1, acc);
    wait_drain(20);
    repeat (3) @(negedge clk);
    vectors++;
    if (credit_err !== 1'b0) begin miscompares++; $display("FAIL self_credit_err got=%b required=0", credit_err); end
  endtask

  initial begin
    test_reset();
    test_credit_overflow();
    test_stall_and_simul();
    test_basic();
    test_len0();
    test_back_to_back();
    test_reset_mid();
    test_self_dest();
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/packet_injector.md
# packet_injector

Local-port packet source for a mesh router node. Accepts a packet request (destination coordinates plus payload length), then emits a head flit, zero or more body flits and exactly one tail flit into the router's local (L) input port. The head flit is laid out so that the router's route computation extracts dest_x/dest_y from its top two coordinate fields. Flow control is credit-based against the local input buffer.

## Interface
- MSB_SLOT, 5, log2 of flit width; only 5 (32-bit flits) is supported.
- DSIZE, 1<<MSB_SLOT, flit width (32).
- RRSIZE, 1<<(MSB_SLOT-2), coordinate field width (8).
- ROUTER_X, 0, this node's X coordinate, placed in the head flit source field.
- ROUTER_Y, 0, this node's Y coordinate, placed in the head flit source field.
- CREDITS, 4, depth of the downstream local input buffer; 1..15.

- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low (0 = reset), sampled on the clk rising edge.
- req_valid  input  1  packet request present.
- req_ready  output  1  block can accept a request; combinational, equals (state==IDLE).
- req_dest_x  input  RRSIZE  destination X.
- req_dest_y  input  RRSIZE  destination Y.
- req_len  input  6  number of payload words, 0..63.
- wr_valid  input  1  payload word present.
- wr_data  input  30  payload word.
- wr_ready  output  1  payload word consumed this edge; combinational, equals (state==SEND_DATA && credit_cnt!=0).
- flit_out  output  DSIZE  registered flit.
- flit_valid  output  1  registered; high for exactly one cycle per flit.
- credit_in  input  1  one-cycle pulse: one downstream buffer slot was freed.
- pkt_done  output  1  registered one-cycle pulse, coincident with the tail flit's flit_valid.
- credit_err  output  1  sticky; set when credit_in arrives while credit_cnt==CREDITS; cleared only by reset.

## Operation
- Flit type field is bits [1:0]: head = 11, body = 01, tail = 10.
- Head flit layout:
  - [31:24] dest_x; [23:16] dest_y.
  - [15:8] = {ROUTER_X[3:0], ROUTER_Y[3:0]}.
  - [7:2] = len; [1:0] = 11.
- Body and tail flit layout: [31:2] = wr_data; type in [1:0].
- States:
  - IDLE:
    - On req_valid && req_ready, latch dest_x, dest_y and len; set remaining = len.
    - Go to SEND_HEAD.
  - SEND_HEAD:
    - If credit_cnt != 0, emit the head flit.
    - Then go to SEND_DATA if len != 0, else go to SEND_ZTAIL.
    - If credit_cnt == 0, hold in SEND_HEAD.
  - SEND_DATA:
    - Each edge with wr_valid && wr_ready emits one flit and decrements remaining.
    - The flit is a body flit if remaining > 1 before the decrement, else a tail flit.
    - After the tail flit, go to IDLE.
    - No wr_valid, or credit_cnt == 0: no flit is emitted and the state holds.
  - SEND_ZTAIL:
    - If credit_cnt != 0, emit a tail flit with [31:2] = 0, without consuming wr, and go to IDLE.
- Credit counter (4 bits):
  - Reset value is CREDITS.
  - Decrements on each emitted flit; increments on credit_in.
  - Both on the same edge: unchanged.
  - credit_in at CREDITS with no emission: counter unchanged and credit_err set.
  - The counter never underflows, because emission requires credit_cnt != 0.
- Destination equal to (ROUTER_X, ROUTER_Y) is legal and is sent unchanged.
- Reset (reset == 0 at an edge), including mid-packet:
  - State goes to IDLE; the partial packet is abandoned and no tail flit is sent.
  - credit_cnt = CREDITS; flit_valid = 0; flit_out = 0; pkt_done = 0; credit_err = 0.

## Timing
- Request accepted at edge k: head flit has flit_valid=1 in the cycle following edge k+1, if credit_cnt != 0 at edge k+1.
- Payload word accepted at edge m: its flit is valid in the cycle following edge m.
- Throughput is one flit per cycle. Back-to-back packets have a minimum of one idle-state cycle, with no flit emitted, between a tail and the next head.
- A packet with length len emits len+1 flits, or 2 flits when len == 0.
- req_ready is low from the acceptance edge until the edge that emits the tail.
- Outputs flit_out, flit_valid and pkt_done are updated only at clock edges. flit_out holds its last value when flit_valid == 0.

## Test plan
- Reset then idle:
  - Expect flit_valid=0, req_ready=1, credit_err=0.
  - Inject 4 credit_in pulses with no traffic: credit_err=1, credit_cnt stays 4.
- Request dest=(2,3), len=2, wr data 0x1234567 and 0x0ABCDEF always valid, ROUTER=(0,0):
  - Flits on consecutive cycles: 0x0203_0008+3 (head), {0x1234567,01}, {0x0ABCDEF,10}.
  - pkt_done coincides with the last flit.
- CREDITS=2, no credit_in, len=3:
  - Exactly 2 flits are emitted (head + first body), then the block stalls with wr_ready=0.
  - A single credit_in releases exactly one more flit.
- len=0:
  - Head flit with [7:2]=0, then a tail flit 0x00000002 on the next cycle.
  - wr_ready never asserts.
- Reset asserted after the head and one body flit of a len=5 packet:
  - The next cycle has flit_valid=0, req_ready=1, credit_cnt=CREDITS.
  - A new request then produces a fresh head flit.
- Simultaneous credit_in and flit emission at credit_cnt=1: count stays 1 and streaming continues without a bubble.
